// File: rtl/dma_mem_responder_pkg.sv
// Shared types and constants for the DMA memory responder.
package dma_mem_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RD   = 3'b010,
    S_WR   = 3'b100
  } state_t;

  localparam int BEAT_LEN_W = 5;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// Burst read/write request and data channels between the DMA engine and the memory responder.
interface dma_mem_responder_if
  import dma_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]             rd_req_addr;
  logic [BEAT_LEN_W-1:0]   rd_req_len;
  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [DATA_WIDTH-1:0]   rd_rdata;
  logic                    rd_valid;
  logic                    rd_last;
  logic                    rd_ready;

  logic [31:0]             wr_req_addr;
  logic [BEAT_LEN_W-1:0]   wr_req_len;
  logic                    wr_req_valid;
  logic                    wr_req_ready;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_valid;
  logic                    wr_ready;
  logic                    wr_last;

  logic                    proto_err;

  modport slave (
    input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
    output rd_req_ready, rd_rdata, rd_valid, rd_last,
    input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
    output wr_req_ready, wr_ready,
    output proto_err
  );

  modport master (
    output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
    input  rd_req_ready, rd_rdata, rd_valid, rd_last,
    output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
    input  wr_req_ready, wr_ready,
    input  proto_err
  );

endinterface

// File: rtl/dma_mem_array.sv
// Word-addressed memory: one synchronous write port, one combinational read port.
module dma_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-side responder serving one read or write burst at a time with round-robin arbitration.
// Optional macro RESP_STALL_EN adds LFSR-driven stalls on the read and write data channels.
module dma_mem_responder
  import dma_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic                clk,
  input logic                rst,
  dma_mem_responder_if.slave bus
);

  state_t                  state, state_next;
  logic                    last_gnt_wr;
  logic [ADDR_WIDTH-1:0]   base;
  logic [BEAT_LEN_W-1:0]   len;
  logic [BEAT_LEN_W-1:0]   beat;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic                    proto_err_r;

  logic                    grant_rd, grant_wr;
  logic                    rd_req_hs, wr_req_hs, rd_hs, wr_hs;
  logic                    beat_is_last;
  logic                    rd_gate, wr_gate;
  logic [ADDR_WIDTH-1:0]   req_base_rd, req_base_wr;
  logic [ADDR_WIDTH-1:0]   cur_addr, next_addr, mem_raddr;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_we;
  logic                    unused_addr_bits;

`ifdef RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  assign rd_gate = lfsr[0];
  assign wr_gate = lfsr[1];
`else
  assign rd_gate = 1'b1;
  assign wr_gate = 1'b1;
`endif

  // A tie goes to whichever channel was not granted last.
  assign grant_rd = bus.rd_req_valid && (!bus.wr_req_valid || last_gnt_wr);
  assign grant_wr = bus.wr_req_valid && (!bus.rd_req_valid || !last_gnt_wr);

  assign rd_req_hs    = bus.rd_req_valid && bus.rd_req_ready;
  assign wr_req_hs    = bus.wr_req_valid && bus.wr_req_ready;
  assign rd_hs        = bus.rd_valid && bus.rd_ready;
  assign wr_hs        = bus.wr_valid && bus.wr_ready;
  assign beat_is_last = (beat == len);

  assign req_base_rd = bus.rd_req_addr[ADDR_WIDTH+1:2];
  assign req_base_wr = bus.wr_req_addr[ADDR_WIDTH+1:2];
  assign cur_addr    = base + ADDR_WIDTH'(beat);
  assign next_addr   = cur_addr + ADDR_WIDTH'(1);
  // Prefetch the beat that will be presented after the current handshake.
  assign mem_raddr   = rd_req_hs ? req_base_rd : next_addr;
  assign mem_we      = wr_hs && !rst;

  assign unused_addr_bits = ^{bus.rd_req_addr[31:ADDR_WIDTH+2], bus.rd_req_addr[1:0],
                              bus.wr_req_addr[31:ADDR_WIDTH+2], bus.wr_req_addr[1:0]};

  dma_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cur_addr),
    .wdata (bus.wr_data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.rd_req_ready = 1'b0;
    bus.wr_req_ready = 1'b0;
    bus.rd_valid     = 1'b0;
    bus.rd_last      = 1'b0;
    bus.wr_ready     = 1'b0;
    case (state)
      S_IDLE: begin
        bus.rd_req_ready = grant_rd;
        bus.wr_req_ready = grant_wr;
        if (grant_rd)      state_next = S_RD;
        else if (grant_wr) state_next = S_WR;
      end
      S_RD: begin
        bus.rd_valid = rd_gate;
        bus.rd_last  = beat_is_last;
        if (rd_gate && bus.rd_ready && beat_is_last) state_next = S_IDLE;
      end
      S_WR: begin
        bus.wr_ready = wr_gate;
        if (wr_gate && bus.wr_valid && beat_is_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_wr <= 1'b1;
      beat        <= '0;
      rdata_r     <= '0;
      proto_err_r <= 1'b0;
    end else if (rd_req_hs) begin
      last_gnt_wr <= 1'b0;
      beat        <= '0;
      rdata_r     <= mem_rdata;
    end else if (wr_req_hs) begin
      last_gnt_wr <= 1'b1;
      beat        <= '0;
    end else if (rd_hs) begin
      beat    <= beat + 5'd1;
      rdata_r <= mem_rdata;
    end else if (wr_hs) begin
      beat <= beat + 5'd1;
      if (bus.wr_last != beat_is_last) proto_err_r <= 1'b1;
    end
  end

  // Burst descriptor only matters once a handshake has loaded it.
  always_ff @(posedge clk) begin
    if (rd_req_hs) begin
      base <= req_base_rd;
      len  <= bus.rd_req_len;
    end else if (wr_req_hs) begin
      base <= req_base_wr;
      len  <= bus.wr_req_len;
    end
  end

  assign bus.rd_rdata  = rdata_r;
  assign bus.proto_err = proto_err_r;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Scoreboard bench for dma_mem_responder: write/read bursts, backpressure, arbitration, wrap, protocol error.
module tb_dma_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] model [1024];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dma_mem_responder_if #(.DATA_WIDTH(32)) bus ();

  dma_mem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.rd_req_addr  = '0;
    bus.rd_req_len   = '0;
    bus.rd_req_valid = 1'b0;
    bus.rd_ready     = 1'b0;
    bus.wr_req_addr  = '0;
    bus.wr_req_len   = '0;
    bus.wr_req_valid = 1'b0;
    bus.wr_data      = '0;
    bus.wr_valid     = 1'b0;
    bus.wr_last      = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int last_at,
                          input logic [31:0] dbase);
    int w;
    int base;
    base = int'(addr[11:2]);
    bus.wr_req_addr  = addr;
    bus.wr_req_len   = 5'(len);
    bus.wr_req_valid = 1'b1;
    #1;
    w = 0;
    while (!bus.wr_req_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    checks++;
    if (w >= 50) begin
      errors++;
      $display("FAIL wr_req_grant: wr_req_ready=%b, required 1 within 50 cycles", bus.wr_req_ready);
      bus.wr_req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.wr_req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = dbase + 32'(i);
      bus.wr_last  = (i == last_at);
      w = 0;
      while (!bus.wr_ready && w < 50) begin
        @(negedge clk); w++;
      end
      checks++;
      if (w >= 50) begin
        errors++;
        $display("FAIL wr_beat_accept: beat %0d wr_ready=%b, required 1", i, bus.wr_ready);
        break;
      end
      model[(base + i) % 1024] = dbase + 32'(i);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_burst_end: wr_ready=%b after %0d beats, required 0", bus.wr_ready, len + 1);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] pat);
    int w, got, cyc, base;
    logic hold;
    logic [31:0] hold_d, exp_d;
    logic [1:0] idx;
    base = int'(addr[11:2]);
    for (int i = 0; i <= len; i++) exp_q.push_back(model[(base + i) % 1024]);
    bus.rd_req_addr  = addr;
    bus.rd_req_len   = 5'(len);
    bus.rd_req_valid = 1'b1;
    #1;
    w = 0;
    while (!bus.rd_req_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    checks++;
    if (w >= 50) begin
      errors++;
      $display("FAIL rd_req_grant: rd_req_ready=%b, required 1 within 50 cycles", bus.rd_req_ready);
      bus.rd_req_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(negedge clk);
    bus.rd_req_valid = 1'b0;
    got = 0; cyc = 0; hold = 1'b0; hold_d = '0;
    while (got <= len && cyc < 300) begin
      idx = cyc[1:0];
      bus.rd_ready = pat[idx];
      if (hold) begin
        checks++;
        if (bus.rd_rdata !== hold_d) begin
          errors++;
          $display("FAIL rd_hold_data: rd_rdata=%h while stalled, required %h", bus.rd_rdata, hold_d);
        end
`ifndef RESP_STALL_EN
        checks++;
        if (bus.rd_valid !== 1'b1) begin
          errors++;
          $display("FAIL rd_hold_valid: rd_valid=%b while stalled, required 1", bus.rd_valid);
        end
`endif
      end
      if (bus.rd_valid === 1'b1) begin
        if (bus.rd_ready) begin
          exp_d = exp_q.pop_front();
          checks++;
          if (bus.rd_rdata !== exp_d) begin
            errors++;
            $display("FAIL rd_data: beat %0d rd_rdata=%h, required %h", got, bus.rd_rdata, exp_d);
          end
          checks++;
          if (bus.rd_last !== (got == len)) begin
            errors++;
            $display("FAIL rd_last: beat %0d rd_last=%b, required %b", got, bus.rd_last, got == len);
          end
          got++;
          hold = 1'b0;
        end else begin
          hold   = 1'b1;
          hold_d = bus.rd_rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.rd_ready = 1'b0;
    checks++;
    if (got <= len) begin
      errors++;
      $display("FAIL rd_beat_count: got %0d beats, required %0d", got, len + 1);
    end
    exp_q.delete();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_burst_end: rd_valid=%b after burst, required 0", bus.rd_valid);
    end
`ifndef RESP_STALL_EN
    if (pat == 4'hF) begin
      checks++;
      if (cyc != len + 1) begin
        errors++;
        $display("FAIL rd_throughput: burst took %0d cycles, required %0d", cyc, len + 1);
      end
    end
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rd_req_ready, bus.wr_req_ready, bus.rd_valid, bus.rd_last, bus.wr_ready, bus.proto_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rrq/wrq/rv/rl/wr/pe=%b, required 000000",
               {bus.rd_req_ready, bus.wr_req_ready, bus.rd_valid, bus.rd_last, bus.wr_ready, bus.proto_err});
    end
    checks++;
    if (bus.rd_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: rd_rdata=%h, required 0", bus.rd_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_rd;
    logic g_rd, g_wr;
    int w;
    exp_rd = 3'b101;
    bus.rd_req_addr  = 32'h300;
    bus.rd_req_len   = 5'd0;
    bus.wr_req_addr  = 32'h304;
    bus.wr_req_len   = 5'd0;
    bus.rd_req_valid = 1'b1;
    bus.wr_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      w = 0;
      while (!(bus.rd_req_ready || bus.wr_req_ready) && w < 50) begin
        @(negedge clk); #1; w++;
      end
      g_rd = bus.rd_req_ready;
      g_wr = bus.wr_req_ready;
      checks++;
      if (g_rd && g_wr) begin
        errors++;
        $display("FAIL arb_exclusive: both request readies high in round %0d, required one", k);
      end
      checks++;
      if (g_rd !== exp_rd[k] || g_wr !== !exp_rd[k]) begin
        errors++;
        $display("FAIL arb_grant: round %0d rd/wr grant=%b%b, required %b%b", k, g_rd, g_wr, exp_rd[k], !exp_rd[k]);
      end
      @(negedge clk);
      if (k == 2) begin
        bus.rd_req_valid = 1'b0;
        bus.wr_req_valid = 1'b0;
      end
      if (g_rd) begin
        bus.rd_ready = 1'b1;
        w = 0;
        while (!bus.rd_valid && w < 50) begin
          @(negedge clk); w++;
        end
        checks++;
        if (bus.rd_last !== 1'b1) begin
          errors++;
          $display("FAIL arb_rd_last: rd_last=%b on single-beat burst, required 1", bus.rd_last);
        end
        @(negedge clk);
        bus.rd_ready = 1'b0;
      end else if (g_wr) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hA5A5_0000 + 32'(k);
        bus.wr_last  = 1'b1;
        w = 0;
        while (!bus.wr_ready && w < 50) begin
          @(negedge clk); w++;
        end
        model[32'h304 >> 2] = 32'hA5A5_0000 + 32'(k);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
      end else begin
        break;
      end
    end
    bus.rd_req_valid = 1'b0;
    bus.wr_req_valid = 1'b0;
    do_read(32'h304, 0, 4'hF);
  endtask

  task automatic test_write_burst();
    do_write(32'h40, 7, 7, 32'h0);
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_proto_ok: proto_err=%b after clean burst, required 0", bus.proto_err);
    end
  endtask

  task automatic test_read_burst();
    do_read(32'h40, 7, 4'hF);
  endtask

  task automatic test_backpressure();
    do_read(32'h40, 7, 4'b1001);
    do_read(32'h44, 2, 4'b0110);
  endtask

  task automatic test_back_to_back();
    do_write(32'h120, 3, 3, 32'hC0DE_0010);
    do_read(32'h120, 3, 4'hF);
    do_write(32'h120, 1, 1, 32'hBEEF_0000);
    do_read(32'h11C, 3, 4'hF);
  endtask

  task automatic test_wrap();
    do_write(32'hFF8, 3, 3, 32'h5A00_0100);
    do_read(32'hFF8, 3, 4'hF);
    do_read(32'h0, 1, 4'hF);
    checks++;
    if (model[0] !== 32'h5A00_0102 || model[1023] !== 32'h5A00_0101) begin
      errors++;
      $display("FAIL wrap_model: words 1023/0=%h/%h, required 5a000101/5a000102", model[1023], model[0]);
    end
  endtask

  task automatic test_early_last();
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_pre: proto_err=%b before bad burst, required 0", bus.proto_err);
    end
    do_write(32'h80, 3, 1, 32'h7700_0000);
    checks++;
    if (bus.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_set: proto_err=%b after early wr_last, required 1", bus.proto_err);
    end
    do_write(32'h90, 0, 0, 32'h7700_0100);
    checks++;
    if (bus.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: proto_err=%b after clean burst, required 1", bus.proto_err);
    end
    do_read(32'h80, 3, 4'hF);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_arbitration();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_early_last();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_mem_responder.md
Name: dma_mem_responder

Overview:
- Memory-side responder for the DMA engine's burst read/write request interfaces; it sits at the far end of the engine's rd_req/rd and wr_req/wr channels.
- Backed by an internal word-addressed memory array.
- Serves one burst at a time, read or write, with round-robin arbitration when both requests are pending.
- Used as the memory model in system benches and as a small on-chip scratch memory.

Parameters:
- DATA_WIDTH, 32, data beat width in bits; only 32 is supported.
- ADDR_WIDTH, 10, log2 of memory depth in words (default depth 1024 words = 4 KiB).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req_addr  in  32  byte address of the read burst; bits [1:0] ignored
- rd_req_len  in  5  read beats minus 1 (0..31)
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted
- rd_rdata  out  32  read beat data
- rd_valid  out  1  read beat valid
- rd_last  out  1  final read beat of the burst
- rd_ready  in  1  initiator accepts the read beat
- wr_req_addr  in  32  byte address of the write burst; bits [1:0] ignored
- wr_req_len  in  5  write beats minus 1
- wr_req_valid  in  1  write request valid
- wr_req_ready  out  1  write request accepted
- wr_data  in  32  write beat data
- wr_valid  in  1  write beat valid
- wr_ready  out  1  responder accepts the write beat
- wr_last  in  1  initiator marks the final write beat
- proto_err  out  1  sticky: wr_last did not coincide with the final counted beat

Behaviour:
- State machine: IDLE, RD, WR (one-hot). Reset drives IDLE.
- Reset values:
  - rd_req_ready, wr_req_ready, rd_valid, rd_last, wr_ready, proto_err = 0.
  - rd_rdata = 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst: no further beats, no further memory writes.
- Arbitration in IDLE (register last_gnt, reset = write, so the first tie goes to read):
  - Only rd_req_valid: grant read. Only wr_req_valid: grant write.
  - Both valid: grant the channel not granted last.
  - rd_req_ready = IDLE && grant_rd; wr_req_ready = IDLE && grant_wr. Both are combinational, never both high.
- On a request handshake, latch:
  - base = addr[ADDR_WIDTH+1:2]
  - len = req_len
  - beat counter = 0
  - last_gnt updated to the granted channel.
- Word address = (base + beat) mod 2^ADDR_WIDTH; wraps silently at the top of memory.
- Read path:
  - At the read request handshake edge, rd_rdata <= mem[base]; state -> RD.
  - In RD, rd_valid = 1 (next cycle after handshake, i.e. 1-cycle latency).
  - On each rd_valid && rd_ready: beat += 1 and rd_rdata <= mem[base+beat+1] on the same edge.
  - rd_rdata and rd_valid hold stable while rd_ready = 0.
  - rd_last = RD && beat == len.
  - Handshake on the last beat -> IDLE.
  - Exactly len+1 beats per burst; a new request cannot be accepted in the same cycle as the last beat (1-cycle bubble).
- Write path:
  - Request handshake -> WR; wr_ready = 1 in WR.
  - On each wr_valid && wr_ready: mem[base+beat] <= wr_data; beat += 1.
  - The burst ends on the handshake with beat == len regardless of wr_last -> IDLE.
  - proto_err set if a handshake has wr_last != (beat == len). Cleared only by rst.
- Read-after-write: a read burst granted after a write burst completes returns the new data (writes are done before the FSM returns to IDLE).
- Beat counter is 5 bits; it is never compared beyond len.

Optional Feature:
- Macro RESP_STALL_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1, reset to seed, advances every cycle) gates the data channels: rd_valid is also qualified by lfsr[0], and wr_ready is also qualified by lfsr[1].
  - While rd_valid is gated low, the beat counter does not advance and rd_rdata stays stable.
  - Request channels are not stalled.
- When undefined: no LFSR; rd_valid and wr_ready are exactly as above (full throughput).

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE, S_RD, S_WR
  - BEAT_LEN_W = 5
  - LFSR seed constant
- Natural sub-module: dma_mem_array (single write port, combinational read port, DATA_WIDTH x 2^ADDR_WIDTH).
- Arbitration, FSM and counters stay in the top.

Test Plan:
- Write burst: addr 0x40, len 7, data 0..7 with wr_last on the 8th beat -> mem words 16..23 = 0..7; proto_err stays 0.
- Read burst: addr 0x40, len 7, rd_ready held 1 -> 8 beats 0..7 on consecutive cycles starting 1 cycle after the handshake; rd_last only on beat 7; then IDLE.
- Read backpressure: rd_ready toggled 1,0,0,1 -> rd_rdata/rd_valid stable during low cycles; no beat lost or duplicated.
- Simultaneous requests: rd_req_valid and wr_req_valid both held high for three bursts after reset -> grants alternate read, write, read.
- Wrap: ADDR_WIDTH=10, write addr 0xFF8, len 3 -> words 1022, 1023, 0, 1 written; read-back matches.
- Early wr_last: len 3 with wr_last on beat 1 -> proto_err = 1 and stays high; burst still ends after 4 beats.
